// File: rtl/svn_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with a double-buffered
// display value that only swaps at frame boundaries, so a frame never shows a mix of two values.
module svn_scan_ctrl #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic        dp,
  output logic [7:0]  AN,
  output logic        blank,
  output logic        frame_done
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_pend_data;
  logic [7:0]    r_pend_dp;
  logic          r_full;
  logic [31:0]   r_active;
  logic [7:0]    r_active_dp;
  logic          r_ready;
  logic [3:0]    r_digit;
  logic          r_dp;
  logic [7:0]    r_an;
  logic          r_blank;
  logic          r_frame_done;

  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_idx_next;
  logic          w_tick;
  logic          w_boundary;
  logic          w_xfer;
  logic          w_load;
  logic          w_full_next;
  logic [31:0]   w_active_next;
  logic [7:0]    w_active_dp_next;
  logic [7:0]    w_upper_zero;
  logic          w_blank_next;
  logic [3:0]    w_digit_next;
  logic          w_dp_next;
  logic [7:0]    w_an_next;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_tick      = (r_cnt == CNT_MAX);
    w_cnt_next  = w_tick ? '0 : r_cnt + CW'(1);
    w_idx_next  = w_tick ? r_idx + 3'd1 : r_idx;
    w_boundary  = w_tick && (r_idx == 3'd7);
    w_xfer      = w_boundary && r_full;
    w_load      = data_valid && r_ready;
    // load and transfer are exclusive: a load needs full=0, a transfer needs full=1
    w_full_next = w_load ? 1'b1 : (w_xfer ? 1'b0 : r_full);
    w_active_next    = w_xfer ? r_pend_data : r_active;
    w_active_dp_next = w_xfer ? r_pend_dp   : r_active_dp;
  end

  // Outputs are computed from next-state values so they change on the same
  // edge as the index, while still coming straight out of flops.
  always_comb begin
    w_upper_zero = '0;
    for (int i = 0; i < 8; i++) begin
      w_upper_zero[i] = ((w_active_next >> (4 * i)) == 32'h0);
    end
    w_blank_next = blank_lz && (w_idx_next != 3'd0) && w_upper_zero[w_idx_next];
    w_digit_next = w_active_next[{w_idx_next, 2'b00} +: 4];
    w_dp_next    = ~w_active_dp_next[w_idx_next];
    w_an_next    = w_blank_next ? 8'hFF : ~(8'b1 << w_idx_next);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      // NOTE: the buffers are a handful of flops, not a RAM, so they are
      // reset along with everything else and a reset discards pending data.
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_pend_data  <= 32'h0;
      r_pend_dp    <= 8'h0;
      r_full       <= 1'b0;
      r_active     <= 32'h0;
      r_active_dp  <= 8'h0;
      r_ready      <= 1'b1;
      r_digit      <= 4'h0;
      r_dp         <= 1'b1;
      r_an         <= 8'hFE;
      r_blank      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_full       <= w_full_next;
      r_ready      <= ~w_full_next;
      r_active     <= w_active_next;
      r_active_dp  <= w_active_dp_next;
      r_digit      <= w_digit_next;
      r_dp         <= w_dp_next;
      r_an         <= w_an_next;
      r_blank      <= w_blank_next;
      r_frame_done <= w_boundary;
      if (w_load) begin
        r_pend_data <= data;
        r_pend_dp   <= dp_mask;
      end
    end
  end

  assign data_ready = r_ready;
  assign digit      = r_digit;
  assign dp         = r_dp;
  assign AN         = r_an;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_svn_scan_ctrl.sv
// Directed bench for svn_scan_ctrl at DIV=4: reset, scan order, leading-zero
// blanking, back-pressure, boundary-cycle loads and mid-scan reset.
module tb_svn_scan_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic        data_valid;
  logic        data_ready;
  logic        blank_lz;
  logic [3:0]  digit;
  logic        dp;
  logic [7:0]  AN;
  logic        blank;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  svn_scan_ctrl #(.DIV(4)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .data       (data),
    .dp_mask    (dp_mask),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .blank_lz   (blank_lz),
    .digit      (digit),
    .dp         (dp),
    .AN         (AN),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle load request issued at a negedge; accepted on the next edge.
  task automatic load(input logic [31:0] d, input logic [7:0] m);
    data       = d;
    dp_mask    = m;
    data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
  endtask

  task automatic wait_frame_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    check({tag, "_wait_fd"}, {31'h0, seen}, 32'h1);
  endtask

  // Starts at the negedge just after a frame boundary; ends at the next one.
  task automatic frame_check(input string tag, input logic [63:0] an_v,
                             input logic [31:0] dg_v, input logic [7:0] dp_v,
                             input logic [7:0] bl_v);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_an%0d", tag, k), {24'h0, AN}, {24'h0, an_v[8*k +: 8]});
      check($sformatf("%s_dg%0d", tag, k), {28'h0, digit}, {28'h0, dg_v[4*k +: 4]});
      check($sformatf("%s_dp%0d", tag, k), {31'h0, dp}, {31'h0, dp_v[k]});
      check($sformatf("%s_bl%0d", tag, k), {31'h0, blank}, {31'h0, bl_v[k]});
      if (k == 0) begin
        step(1);
        check({tag, "_fd_low"}, {31'h0, frame_done}, 32'h0);
        step(3);
      end else begin
        step(4);
      end
    end
    check({tag, "_fd_next"}, {31'h0, frame_done}, 32'h1);
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    data       = 32'h0;
    dp_mask    = 8'h0;
    data_valid = 1'b0;
    blank_lz   = 1'b0;

    // Reset held for two edges
    step(2);
    check("rst_an",    {24'h0, AN}, 32'hFE);
    check("rst_digit", {28'h0, digit}, 32'h0);
    check("rst_dp",    {31'h0, dp}, 32'h1);
    check("rst_blank", {31'h0, blank}, 32'h0);
    check("rst_ready", {31'h0, data_ready}, 32'h1);
    check("rst_fd",    {31'h0, frame_done}, 32'h0);
    sys_rst_n = 1'b1;
    step(3);
    check("pre_tick_an", {24'h0, AN}, 32'hFE);
    step(1);
    check("first_tick_an", {24'h0, AN}, 32'hFD);

    // Normal scan
    check("scan_ready_pre", {31'h0, data_ready}, 32'h1);
    load(32'h87654321, 8'h04);
    check("scan_ready_post", {31'h0, data_ready}, 32'h0);
    wait_frame_done("scan");
    check("scan_ready_xfer", {31'h0, data_ready}, 32'h1);
    frame_check("scan", 64'h7FBF_DFEF_F7FB_FDFE, 32'h87654321, 8'hFB, 8'h00);

    // Leading-zero blanking
    blank_lz = 1'b1;
    load(32'h00000120, 8'h00);
    wait_frame_done("lz");
    frame_check("lz", 64'hFFFF_FFFF_FFFB_FDFE, 32'h00000120, 8'hFF, 8'hF8);
    load(32'h00000000, 8'h00);
    wait_frame_done("zero");
    frame_check("zero", 64'hFFFF_FFFF_FFFF_FFFE, 32'h00000000, 8'hFF, 8'hFE);
    blank_lz = 1'b0;

    // Back-pressure: second request in the same frame is ignored
    step(2);
    load(32'hA1B2C3D4, 8'h00);
    check("bp_ready_after_first", {31'h0, data_ready}, 32'h0);
    step(3);
    check("bp_ready_before_second", {31'h0, data_ready}, 32'h0);
    load(32'h11111111, 8'hFF);
    check("bp_ready_after_second", {31'h0, data_ready}, 32'h0);
    wait_frame_done("bp");
    check("bp_ready_boundary", {31'h0, data_ready}, 32'h1);
    frame_check("bp", 64'h7FBF_DFEF_F7FB_FDFE, 32'hA1B2C3D4, 8'hFF, 8'h00);

    // Request in the boundary-tick cycle with pending full
    load(32'h55555555, 8'h00);
    step(30);
    data       = 32'h99999999;
    dp_mask    = 8'h80;
    data_valid = 1'b1;
    check("sim_ready_at_boundary", {31'h0, data_ready}, 32'h0);
    step(1);
    check("sim_fd",          {31'h0, frame_done}, 32'h1);
    check("sim_ready_after", {31'h0, data_ready}, 32'h1);
    step(1);
    data_valid = 1'b0;
    check("sim_ready_accept", {31'h0, data_ready}, 32'h0);
    check("sim_shown_digit",  {28'h0, digit}, 32'h5);
    check("sim_shown_an",     {24'h0, AN}, 32'hFE);
    step(31);
    check("sim_fd2", {31'h0, frame_done}, 32'h1);
    frame_check("sim", 64'h7FBF_DFEF_F7FB_FDFE, 32'h99999999, 8'h7F, 8'h00);

    // Reset pulse at idx 5 with pending full
    load(32'h3C3C3C3C, 8'hFF);
    step(20);
    check("mr_an_idx5", {24'h0, AN}, 32'hDF);
    sys_rst_n = 1'b0;
    step(1);
    sys_rst_n = 1'b1;
    check("mr_an",    {24'h0, AN}, 32'hFE);
    check("mr_digit", {28'h0, digit}, 32'h0);
    check("mr_dp",    {31'h0, dp}, 32'h1);
    check("mr_ready", {31'h0, data_ready}, 32'h1);
    check("mr_fd",    {31'h0, frame_done}, 32'h0);
    wait_frame_done("mr");
    check("mr_discard_digit", {28'h0, digit}, 32'h0);
    check("mr_discard_dp",    {31'h0, dp}, 32'h1);
    check("mr_discard_ready", {31'h0, data_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
